pau_arbiter: RTL
================

# pau_arbiter

Shares one posit arithmetic unit (add/mul/div operators with a level `start` and a `done` flag) between `NUM_REQ` requesters, e.g. several CVXIF coprocessor front-ends. The block does four things: round-robin arbitration over operation requests, latching operands and opcode, sequencing the unit with a minimum-wait/timeout counter, and returning the result to the granted requester over a valid/ready channel. It sits between the CVXIF decode FSMs and the shared posit datapath.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `PAU_N`, 32: posit word width.
- `OP_W`, 3: opcode width (funct3), forwarded to the unit unchanged.
- `WAIT_TIME`, 4: minimum cycles `start` is held before `done` is sampled.
- `TIMEOUT`, 64: cycle count at which an operation is abandoned. Must be greater than `WAIT_TIME`.
- `CNT_W`, 8: counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_op`  in  NUM_REQ*OP_W  opcodes, requester i at slice [i*OP_W +: OP_W].
- `req_a`, `req_b`  in  NUM_REQ*PAU_N each  operands, same slicing.
- `resp_valid`  out  NUM_REQ  one-hot result valid to the owner.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `resp_data`  out  PAU_N  shared result bus.
- `resp_err`  out  1  1 = timeout, `resp_data` = 0.
- `owner`  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- `busy`  out  1  high in every state except IDLE.
- `pau_start`  out  1  level start to the unit.
- `pau_op`  out  OP_W  registered opcode.
- `pau_a`, `pau_b`  out  PAU_N each  registered operands.
- `pau_done`  in  1  unit done.
- `pau_result`  in  PAU_N  unit result, already selected by op.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - Grant is combinational: the first requester with `req_valid` = 1, searching from `rr_ptr` upward with wrap.
  - Only that requester's `req_ready` is 1. All `req_ready` are 0 when there is no request.
  - On handshake: latch op/a/b into `pau_*`, set `owner`, set `rr_ptr` = (granted+1) mod NUM_REQ, clear the counter, go to WAIT.
- **WAIT**
  - `pau_start` = 1. `pau_*` are held stable. The counter increments every cycle, saturating at TIMEOUT.
  - If counter >= WAIT_TIME and `pau_done` = 1: capture `pau_result` into `resp_data`, set `resp_err` = 0, go to RESP.
  - Else if counter == TIMEOUT: set `resp_data` = 0, set `resp_err` = 1, go to RESP.
  - `done` is ignored while counter < WAIT_TIME.
- **RESP**
  - `pau_start` = 0. `resp_valid[owner]` = 1.
  - When `resp_ready[owner]` = 1, go to IDLE. `resp_ready` of non-owners is ignored.
  - `resp_data` and `resp_err` are held until the next capture.
- Requests are never queued. A requester keeps `req_valid` high until granted. There is at most one operation in flight.
- Reset (`rst` = 0 at an edge), including mid-operation:
  - Go to IDLE. The in-flight operation is discarded with no response.
  - Set `rr_ptr` = 0, counter = 0, `owner` = 0, `resp_data` = 0, `resp_err` = 0, `pau_op`/`pau_a`/`pau_b` = 0.

## Timing
- Reset values: `req_ready` is combinational; the first cycle after reset follows the IDLE grant rule. All of the following are 0: `resp_valid`, `pau_start`, `busy`, `pau_*`, `resp_data`, `resp_err`, `owner`.
- Let T0 be the accept edge (`req_valid`&`req_ready`). Then:
  - T0+1: WAIT with counter = 0, `pau_start` = 1, `pau_*` valid.
  - The counter equals k at T0+1+k.
  - Earliest capture edge: T0+1+WAIT_TIME.
  - `resp_valid` from T0+2+WAIT_TIME. Minimum accept-to-response latency is WAIT_TIME+2 cycles.
- Timeout: the capture edge is T0+1+TIMEOUT, and `resp_valid` rises with `resp_err` = 1 at T0+2+TIMEOUT.
- A response consumed at edge R returns the block to IDLE at R. The next grant handshake is no earlier than R+1, so `pau_start` is low for at least 2 cycles between operations (RESP + IDLE). This gives the unit's start-level restart.
- Simultaneous requests: exactly one grant per IDLE cycle. Requester i granted means requester (i+1) mod NUM_REQ has top priority next time, so each requester waits at most NUM_REQ-1 operations.
- `pau_done` arriving on the same edge that the counter reaches TIMEOUT is treated as a success (the done check has priority).
- `req_valid` changes while not in IDLE have no effect.

## Test plan
- **Single op:** NUM_REQ = 2, WAIT_TIME = 4, req0 op = 3'b000, a = 32'h4000_0000, b = 32'h4000_0000; unit model asserts done with result 32'h4800_0000 from start+2.
  - Expect `req_ready[0]` at T0, `pau_start` high T0+1..T0+5, `resp_valid[0]` at T0+6, `resp_data` = 32'h4800_0000, `resp_err` = 0.
- **Round-robin:** req0 and req1 both held valid for 4 operations.
  - Expect grants in order 0,1,0,1 and `owner` matching.
  - No grant while busy; `pau_start` low for at least 2 cycles between ops.
- **Timeout:** TIMEOUT = 16, done never asserted.
  - Expect `resp_valid` at T0+18 with `resp_err` = 1 and `resp_data` = 0. The next op completes normally.
- **Backpressure:** `resp_ready[1]` held low for 10 cycles.
  - Expect `resp_valid[1]` and `resp_data` stable, `req_ready` all 0, and `resp_ready[0]` = 1 ignored. The block returns to IDLE the cycle after `resp_ready[1]` rises.
- **Early done ignored:** done = 1 from T0+1 with result 32'h1234_5678.
  - Expect capture at T0+5 only, `resp_valid` at T0+6 with that data.
- **Reset mid-op:** `rst` = 0 for one cycle during WAIT with req1 owning.
  - Expect next-cycle `pau_start` = 0, `busy` = 0, no `resp_valid`, `rr_ptr` = 0 (req0 wins the next contested grant).

Source files
------------

// File: rtl/pau_arbiter.sv
// pau_arbiter: shares one posit arithmetic unit between NUM_REQ requesters with round-robin
// grant, operand latching, minimum-wait/timeout sequencing and a valid/ready result return.
//
// state | meaning
// IDLE  | no operation in flight; combinational round-robin grant offered on req_ready
// WAIT  | operands latched, pau_start held, counting toward done or timeout
// RESP  | result (or timeout error) offered to the owner until it accepts
module pau_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int PAU_N     = 32,
  parameter int OP_W      = 3,
  parameter int WAIT_TIME = 4,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OP_W-1:0]      req_op,
  input  logic [NUM_REQ*PAU_N-1:0]     req_a,
  input  logic [NUM_REQ*PAU_N-1:0]     req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [PAU_N-1:0]             resp_data,
  output logic                         resp_err,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         busy,
  output logic                         pau_start,
  output logic [OP_W-1:0]              pau_op,
  output logic [PAU_N-1:0]             pau_a,
  output logic [PAU_N-1:0]             pau_b,
  input  logic                         pau_done,
  input  logic [PAU_N-1:0]             pau_result
);

  localparam int OWN_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [OWN_W-1:0]   r_rr;
  logic [OWN_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [PAU_N-1:0]   r_resp_data;
  logic               r_resp_err;
  logic               r_busy;
  logic               r_pau_start;
  logic [OP_W-1:0]    r_pau_op;
  logic [PAU_N-1:0]   r_pau_a;
  logic [PAU_N-1:0]   r_pau_b;

  logic [OP_W-1:0]    w_op_arr [NUM_REQ];
  logic [PAU_N-1:0]   w_a_arr  [NUM_REQ];
  logic [PAU_N-1:0]   w_b_arr  [NUM_REQ];
  logic               w_grant_vld;
  logic [OWN_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [OWN_W-1:0]   w_rr_next;
  logic               w_min_met;
  logic               w_timeout;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_arr[g] = req_op[g*OP_W +: OP_W];
    assign w_a_arr[g]  = req_a[g*PAU_N +: PAU_N];
    assign w_b_arr[g]  = req_b[g*PAU_N +: PAU_N];
  end

  // Scan from lowest to highest priority so the requester closest to r_rr wins last.
  always_comb begin
    logic [OWN_W-1:0] v_idx;
    v_idx       = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = OWN_W'((int'(r_rr) + k) % NUM_REQ);
      if (req_valid[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_idx;
      end
    end
    w_grant_oh              = '0;
    w_grant_oh[w_grant_idx] = 1'b1;
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_rr_next = (w_grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_min_met = (r_cnt >= CNT_W'(WAIT_TIME));
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

  assign req_ready = (r_state == S_IDLE && w_grant_vld) ? w_grant_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rr         <= '0;
      r_owner      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
      r_pau_start  <= 1'b0;
      r_pau_op     <= '0;
      r_pau_a      <= '0;
      r_pau_b      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_pau_op    <= w_op_arr[w_grant_idx];
            r_pau_a     <= w_a_arr[w_grant_idx];
            r_pau_b     <= w_b_arr[w_grant_idx];
            r_owner     <= w_grant_idx;
            r_rr        <= w_rr_next;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_pau_start <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_timeout) r_cnt <= r_cnt + 1'b1;
          // done wins over timeout when both land on the same edge
          if (w_min_met && pau_done) begin
            r_resp_data  <= pau_result;
            r_resp_err   <= 1'b0;
            r_resp_valid <= w_owner_oh;
            r_pau_start  <= 1'b0;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= w_owner_oh;
            r_pau_start  <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[r_owner]) begin
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_busy       <= 1'b0;
          r_pau_start  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign pau_start  = r_pau_start;
  assign pau_op     = r_pau_op;
  assign pau_a      = r_pau_a;
  assign pau_b      = r_pau_b;

endmodule
